// File: rtl/bias_pkg.sv
// Shared constants and types for the output-layer bias loader.
// Holds the bias geometry, the bias byte type and the loader state type.
package bias_pkg;

    localparam int NUM_BIAS = 10;
    localparam int BIAS_W   = 8;
    localparam int ADDR_W   = 4;

    typedef logic [BIAS_W-1:0] bias_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        READY = 2'd2
    } state_t;

endpackage

// File: rtl/bias_output_loader_sm_to_tc.sv
// Combinational sign-magnitude to two's-complement converter (BIAS_W wide).
// Ports: sm = sign-magnitude input, tc = two's-complement output.
module sm_to_tc
    import bias_pkg::*;
(
    input  bias_t sm,
    output bias_t tc
);

    bias_t mag;

    // Negative zero has a zero magnitude, so negation folds it onto +0.
    assign mag = {1'b0, sm[BIAS_W-2:0]};
    assign tc  = sm[BIAS_W-1] ? (BIAS_W'(0) - mag) : sm;

endmodule

// File: rtl/bias_output_loader.sv
// Writable output-layer bias register file: stream load plus registered read.
// Ports: clk, rst (sync, active-high), start, in_valid/in_data/in_ready,
// loaded, done, rd_en/rd_addr/rd_data/rd_err. Macro BIAS_SM2TC_EN converts
// read data from sign-magnitude to two's complement.
module bias_output_loader
    import bias_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              in_valid,
    input  logic [BIAS_W-1:0] in_data,
    output logic              in_ready,
    output logic              loaded,
    output logic              done,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [BIAS_W-1:0] rd_data,
    output logic              rd_err
);

    state_t            state;
    logic [ADDR_W-1:0] wr_idx;
    bias_t             mem [NUM_BIAS];

    logic  we;
    logic  last;
    logic  rd_hit;
    bias_t rd_raw;
    bias_t rd_conv;

    // A start pulse blocks the handshake so an aborting cycle never writes.
    assign in_ready = (state == LOAD) && !start;
    assign we       = in_valid && in_ready;
    assign last     = (wr_idx == ADDR_W'(NUM_BIAS - 1));
    assign rd_hit   = (int'(rd_addr) < NUM_BIAS);

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            wr_idx <= '0;
            loaded <= 1'b0;
            done   <= 1'b0;
        end else begin
            done <= 1'b0;
            if (start) begin
                state  <= LOAD;
                wr_idx <= '0;
                loaded <= 1'b0;
            end else begin
                unique case (state)
                    IDLE, READY: ;
                    LOAD: begin
                        if (we) begin
                            if (last) begin
                                state  <= READY;
                                wr_idx <= '0;
                                loaded <= 1'b1;
                                done   <= 1'b1;
                            end else begin
                                wr_idx <= wr_idx + 1'b1;
                            end
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_BIAS; i++) begin
                mem[i] <= '0;
            end
        end else if (we) begin
            mem[wr_idx] <= in_data;
        end
    end

    always_comb begin
        rd_raw = '0;
        if (rd_hit) begin
            rd_raw = mem[rd_addr];
        end
    end

`ifdef BIAS_SM2TC_EN
    sm_to_tc u_sm_to_tc (
        .sm (rd_raw),
        .tc (rd_conv)
    );
`else
    assign rd_conv = rd_raw;
`endif

    // Sampling mem before the write edge gives read-before-write ordering.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_data <= '0;
            rd_err  <= 1'b0;
        end else begin
            rd_err <= rd_en && !rd_hit;
            if (rd_en) begin
                rd_data <= rd_hit ? rd_conv : '0;
            end
        end
    end

endmodule

// File: tb/tb_bias_output_loader.sv
// Randomized scoreboard bench for bias_output_loader.
// Reference model: array of stored bytes plus a load-sequence index.
module tb_bias_output_loader;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic       in_valid;
    logic [7:0] in_data;
    logic       in_ready;
    logic       loaded;
    logic       done;
    logic       rd_en;
    logic [3:0] rd_addr;
    logic [7:0] rd_data;
    logic       rd_err;

    int errors = 0;
    int checks = 0;

    bias_output_loader dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .in_valid (in_valid),
        .in_data  (in_data),
        .in_ready (in_ready),
        .loaded   (loaded),
        .done     (done),
        .rd_en    (rd_en),
        .rd_addr  (rd_addr),
        .rd_data  (rd_data),
        .rd_err   (rd_err)
    );

    always #5 clk = ~clk;

    // Model: 0 = idle, 1 = loading, 2 = complete set held.
    int         m_phase;
    int         m_idx;
    logic       m_loaded;
    logic [7:0] m_mem [10];

    logic [8:0] exp_q [$];
    logic       rd_pend;
    logic [7:0] hold_val;

    function automatic logic [7:0] ref_conv(input logic [7:0] b);
`ifdef BIAS_SM2TC_EN
        int v;
        v = b[7] ? -int'(b[6:0]) : int'(b);
        return v[7:0];
`else
        return b;
`endif
    endfunction

    task automatic chk(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    task automatic model_reset();
        m_phase  = 0;
        m_idx    = 0;
        m_loaded = 1'b0;
        for (int i = 0; i < 10; i++) m_mem[i] = 8'h00;
    endtask

    task automatic do_reset();
        rst = 1'b1; start = 0; in_valid = 0; in_data = 0;
        rd_en = 0; rd_addr = 0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b0;
        model_reset();
        hold_val = 8'h00;
        chk("rst_in_ready", int'(in_ready), 0);
        chk("rst_loaded", int'(loaded), 0);
        chk("rst_done", int'(done), 0);
    endtask

    task automatic step(input logic s, input logic v, input logic [7:0] d,
                        input logic re, input logic [3:0] ra);
        logic exp_done;
        start = s; in_valid = v; in_data = d;
        rd_en = re; rd_addr = ra;
        #1;
        chk("in_ready", int'(in_ready), int'((m_phase == 1) && !s));
        if (re) begin
            if (ra < 10) exp_q.push_back({1'b0, ref_conv(m_mem[ra])});
            else exp_q.push_back({1'b1, 8'h00});
        end
        exp_done = 1'b0;
        if (s) begin
            m_phase = 1; m_idx = 0; m_loaded = 1'b0;
        end else if (m_phase == 1 && v) begin
            m_mem[m_idx] = d;
            if (m_idx == 9) begin
                m_phase = 2; m_idx = 0; m_loaded = 1'b1; exp_done = 1'b1;
            end else begin
                m_idx++;
            end
        end
        @(posedge clk); #1;
        chk("done", int'(done), int'(exp_done));
        chk("loaded", int'(loaded), int'(m_loaded));
    endtask

    task automatic idle(); step(0, 0, 8'h00, 0, 4'd0); endtask

    task automatic read_all(input int n);
        for (int a = 0; a < n; a++) step(0, 0, 8'h00, 1, 4'(a));
    endtask

    always @(posedge clk) rd_pend <= rd_en && !rst;

    always @(negedge clk) begin
        logic [8:0] e;
        if (rst) begin
            hold_val = 8'h00;
        end else if (rd_pend) begin
            if (exp_q.size() == 0) begin
                chk("rd_unexpected", 1, 0);
            end else begin
                e = exp_q.pop_front();
                chk("rd_data", int'(rd_data), int'(e[7:0]));
                chk("rd_err", int'(rd_err), int'(e[8]));
                hold_val = e[7:0];
            end
        end else begin
            chk("rd_hold", int'(rd_data), int'(hold_val));
            chk("rd_err_idle", int'(rd_err), 0);
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        logic [7:0] set_a [10];
        logic [7:0] set_sm [4];
        set_a = '{8'h83, 8'hAE, 8'h23, 8'h02, 8'h15,
                  8'h03, 8'h9F, 8'hC6, 8'h56, 8'h07};
        set_sm = '{8'h83, 8'h80, 8'h7F, 8'hFF};
        rd_pend = 1'b0;

        do_reset();
        read_all(10);
        step(0, 1, 8'hAA, 0, 0);
        read_all(1);

        step(1, 1, 8'hEE, 0, 0);
        for (int i = 0; i < 10; i++) step(0, 1, set_a[i], 0, 0);
        idle();
        read_all(10);

        step(1, 0, 8'h00, 0, 0);
        for (int i = 0; i < 10; i++) begin
            step(0, 0, 8'h11, 0, 0);
            step(0, 1, set_a[9 - i], 0, 0);
        end
        idle();
        read_all(10);

        step(1, 0, 8'h00, 0, 0);
        for (int i = 0; i < 4; i++) step(0, 1, 8'hF0 + 8'(i), 0, 0);
        read_all(10);
        step(1, 1, 8'hCC, 0, 0);
        for (int i = 0; i < 10; i++) step(0, 1, 8'(i + 1), 0, 0);
        read_all(10);
        step(0, 0, 8'h00, 1, 4'd10);
        step(0, 0, 8'h00, 1, 4'd15);
        idle();

        step(1, 0, 8'h00, 0, 0);
        for (int i = 0; i < 3; i++) step(0, 1, 8'h20 + 8'(i), 0, 0);
        step(0, 1, 8'h55, 1, 4'd3);
        step(0, 0, 8'h00, 1, 4'd3);
        for (int i = 4; i < 10; i++) step(0, 1, 8'h30 + 8'(i), 0, 0);
        read_all(10);

        step(1, 0, 8'h00, 0, 0);
        for (int i = 0; i < 4; i++) step(0, 1, set_sm[i], 0, 0);
        read_all(4);

        for (int n = 0; n < 400; n++) begin
            step($urandom_range(0, 29) == 0, 1'($urandom),
                 8'($urandom), 1'($urandom), 4'($urandom));
        end

        step(1, 0, 8'h00, 0, 0);
        for (int i = 0; i < 5; i++) step(0, 1, 8'($urandom), 0, 0);
        do_reset();
        read_all(16);
        step(0, 1, 8'h77, 0, 0);
        idle();
        idle();
        chk("queue_drained", exp_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
